// File: rtl/mc_control_fsm_pkg.sv
// Shared types and encodings for the multicycle control unit.
// Optional IMM_LOGIC_EN adds the zext field for andi/ori support.
package mc_ctrl_pkg;

    typedef enum logic [3:0] {
        S_FETCH, S_DECODE, S_MEMADR, S_MEMRD, S_MEMWB, S_MEMWR, S_EXECUTE,
        S_ALUWB, S_BRANCH, S_ADDIEXEC, S_ADDIWB, S_JUMP, S_IMMEXEC
    } state_t;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_ANDI  = 6'b001100;
    localparam logic [5:0] OP_ORI   = 6'b001101;

    localparam logic [5:0] FN_ADD = 6'b100000;
    localparam logic [5:0] FN_SUB = 6'b100010;
    localparam logic [5:0] FN_AND = 6'b100100;
    localparam logic [5:0] FN_OR  = 6'b100101;
    localparam logic [5:0] FN_SLT = 6'b101010;

    localparam logic [2:0] ALU_ADD = 3'b010;
    localparam logic [2:0] ALU_SUB = 3'b110;
    localparam logic [2:0] ALU_AND = 3'b000;
    localparam logic [2:0] ALU_OR  = 3'b001;
    localparam logic [2:0] ALU_SLT = 3'b111;

    localparam logic [1:0] SRCB_B     = 2'b00;
    localparam logic [1:0] SRCB_FOUR  = 2'b01;
    localparam logic [1:0] SRCB_IMM   = 2'b10;
    localparam logic [1:0] SRCB_IMMSH = 2'b11;

    localparam logic [1:0] PCSRC_ALU    = 2'b00;
    localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
    localparam logic [1:0] PCSRC_JUMP   = 2'b10;

    // Registered Moore outputs; branch/pcwrite feed the pcen term.
    typedef struct packed {
        logic       memwrite;
        logic       regwrite;
        logic       iord;
        logic       memtoreg;
        logic       regdst;
        logic       alusrca;
        logic       branch;
        logic       pcwrite;
        logic [1:0] alusrcb;
        logic [1:0] pcsrc;
        logic [2:0] alucontrol;
`ifdef IMM_LOGIC_EN
        logic       zext;
`endif
    } ctrl_t;

endpackage

// File: rtl/mc_control_fsm_if.sv
// Control bus between the instruction register/datapath and the control FSM.
// zext exists only when IMM_LOGIC_EN is defined.
interface mc_control_fsm_if;
    logic [5:0] op;
    logic [5:0] funct;
    logic       zero;
    logic       mem_ready;
    logic       pcen;
    logic       memwrite;
    logic       irwrite;
    logic       regwrite;
    logic       iord;
    logic       memtoreg;
    logic       regdst;
    logic       alusrca;
    logic [1:0] alusrcb;
    logic [1:0] pcsrc;
    logic [2:0] alucontrol;
    logic       illegal;
`ifdef IMM_LOGIC_EN
    logic       zext;
`endif

    modport master (
        input  op, funct, zero, mem_ready,
        output pcen, memwrite, irwrite, regwrite, iord, memtoreg, regdst,
               alusrca, alusrcb, pcsrc, alucontrol, illegal
`ifdef IMM_LOGIC_EN
        , output zext
`endif
    );

    modport slave (
        output op, funct, zero, mem_ready,
        input  pcen, memwrite, irwrite, regwrite, iord, memtoreg, regdst,
               alusrca, alusrcb, pcsrc, alucontrol, illegal
`ifdef IMM_LOGIC_EN
        , input zext
`endif
    );
endinterface

// File: rtl/mc_control_fsm_alu_ctrl_dec.sv
// R-type funct decoder: funct -> ALU function select plus unsupported-funct flag.
module alu_ctrl_dec
    import mc_ctrl_pkg::*;
(
    input  logic [5:0] funct,
    output logic [2:0] alucontrol,
    output logic       funct_illegal
);
    always_comb begin
        alucontrol    = ALU_ADD;
        funct_illegal = 1'b0;
        case (funct)
            FN_ADD:  alucontrol = ALU_ADD;
            FN_SUB:  alucontrol = ALU_SUB;
            FN_AND:  alucontrol = ALU_AND;
            FN_OR:   alucontrol = ALU_OR;
            FN_SLT:  alucontrol = ALU_SLT;
            default: funct_illegal = 1'b1;
        endcase
    end
endmodule

// File: rtl/mc_control_fsm.sv
// Multicycle control FSM: sequences FETCH..writeback and drives datapath selects.
// Define IMM_LOGIC_EN to add andi/ori via the IMMEXEC state and the zext output.
module mc_control_fsm
    import mc_ctrl_pkg::*;
#(
    parameter bit MEM_HANDSHAKE = 1'b1
) (
    input  logic             clk,
    input  logic             reset_n,
    mc_control_fsm_if.master bus
);
    state_t     state;
    state_t     nstate;
    ctrl_t      ctrl;
    logic       armed;
    logic       mr;
    logic       op_illegal;
    logic       fetch_go;
    logic [2:0] funct_alu;
    logic       funct_illegal;

    alu_ctrl_dec u_alu_ctrl_dec (
        .funct         (bus.funct),
        .alucontrol    (funct_alu),
        .funct_illegal (funct_illegal)
    );

    assign mr       = MEM_HANDSHAKE ? bus.mem_ready : 1'b1;
    // The first cycle after reset is a dead fetch: outputs stay 0 and no IR load happens.
    assign fetch_go = (state == S_FETCH) && armed && mr;

    always_comb begin
        op_illegal = 1'b0;
        case (bus.op)
            OP_LW, OP_SW, OP_BEQ, OP_ADDI, OP_J: op_illegal = 1'b0;
            OP_RTYPE: op_illegal = funct_illegal;
`ifdef IMM_LOGIC_EN
            OP_ANDI, OP_ORI: op_illegal = 1'b0;
`endif
            default: op_illegal = 1'b1;
        endcase
    end

    always_comb begin
        nstate = S_FETCH;
        case (state)
            S_FETCH:    nstate = fetch_go ? S_DECODE : S_FETCH;
            S_DECODE: begin
                case (bus.op)
                    OP_LW, OP_SW: nstate = S_MEMADR;
                    OP_RTYPE:     nstate = funct_illegal ? S_FETCH : S_EXECUTE;
                    OP_BEQ:       nstate = S_BRANCH;
                    OP_ADDI:      nstate = S_ADDIEXEC;
                    OP_J:         nstate = S_JUMP;
`ifdef IMM_LOGIC_EN
                    OP_ANDI, OP_ORI: nstate = S_IMMEXEC;
`endif
                    default:      nstate = S_FETCH;
                endcase
            end
            S_MEMADR:   nstate = (bus.op == OP_SW) ? S_MEMWR : S_MEMRD;
            S_MEMRD:    nstate = mr ? S_MEMWB : S_MEMRD;
            S_MEMWB:    nstate = S_FETCH;
            S_MEMWR:    nstate = mr ? S_FETCH : S_MEMWR;
            S_EXECUTE:  nstate = S_ALUWB;
            S_ALUWB:    nstate = S_FETCH;
            S_BRANCH:   nstate = S_FETCH;
            S_ADDIEXEC: nstate = S_ADDIWB;
            S_ADDIWB:   nstate = S_FETCH;
            S_JUMP:     nstate = S_FETCH;
            S_IMMEXEC:  nstate = S_ADDIWB;
            default:    nstate = S_FETCH;
        endcase
    end

    // Outputs are registered by decoding the state being entered.
    function automatic ctrl_t outs_for(input state_t s, input logic [2:0] falu,
                                       input logic imm_or);
        ctrl_t c;
        c            = '0;
        c.alucontrol = ALU_ADD;
        case (s)
            S_FETCH:    c.alusrcb = SRCB_FOUR;
            S_DECODE:   c.alusrcb = SRCB_IMMSH;
            S_MEMADR:   begin c.alusrca = 1'b1; c.alusrcb = SRCB_IMM; end
            S_MEMRD:    c.iord = 1'b1;
            S_MEMWB:    begin c.memtoreg = 1'b1; c.regwrite = 1'b1; end
            S_MEMWR:    begin c.iord = 1'b1; c.memwrite = 1'b1; end
            S_EXECUTE:  begin c.alusrca = 1'b1; c.alusrcb = SRCB_B; c.alucontrol = falu; end
            S_ALUWB:    begin c.regdst = 1'b1; c.regwrite = 1'b1; end
            S_BRANCH: begin
                c.alusrca    = 1'b1;
                c.alucontrol = ALU_SUB;
                c.pcsrc      = PCSRC_ALUOUT;
                c.branch     = 1'b1;
            end
            S_ADDIEXEC: begin c.alusrca = 1'b1; c.alusrcb = SRCB_IMM; end
            S_ADDIWB:   c.regwrite = 1'b1;
            S_JUMP:     begin c.pcsrc = PCSRC_JUMP; c.pcwrite = 1'b1; end
            S_IMMEXEC: begin
                c.alusrca    = 1'b1;
                c.alusrcb    = SRCB_IMM;
                c.alucontrol = imm_or ? ALU_OR : ALU_AND;
`ifdef IMM_LOGIC_EN
                c.zext       = 1'b1;
`endif
            end
            default:    c.alucontrol = ALU_ADD;
        endcase
        return c;
    endfunction

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state <= S_FETCH;
            armed <= 1'b0;
            ctrl  <= '0;
        end else begin
            state <= nstate;
            armed <= 1'b1;
            ctrl  <= outs_for(nstate, funct_alu, bus.op[0]);
        end
    end

    assign bus.irwrite    = fetch_go;
    assign bus.pcen       = fetch_go | ctrl.pcwrite | (ctrl.branch & bus.zero);
    assign bus.memwrite   = ctrl.memwrite;
    assign bus.regwrite   = ctrl.regwrite;
    assign bus.iord       = ctrl.iord;
    assign bus.memtoreg   = ctrl.memtoreg;
    assign bus.regdst     = ctrl.regdst;
    assign bus.alusrca    = ctrl.alusrca;
    assign bus.alusrcb    = ctrl.alusrcb;
    assign bus.pcsrc      = ctrl.pcsrc;
    assign bus.alucontrol = ctrl.alucontrol;
    assign bus.illegal    = (state == S_DECODE) && op_illegal;
`ifdef IMM_LOGIC_EN
    assign bus.zext       = ctrl.zext;
`endif
endmodule

// File: tb/tb_mc_control_fsm.sv
// Directed bench for mc_control_fsm: walks each instruction class cycle by cycle.
module tb_mc_control_fsm;
    import mc_ctrl_pkg::*;

    logic clk = 1'b0;
    logic reset_n;
    int   n_tests = 0;
    int   n_fail  = 0;

    mc_control_fsm_if bus ();

    mc_control_fsm #(.MEM_HANDSHAKE(1'b1)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    always #5 clk = ~clk;

    // {pcen,memwrite,irwrite,regwrite,iord,memtoreg,regdst,alusrca, alusrcb, pcsrc, alucontrol, illegal}
    logic [15:0] outs;
    assign outs = {bus.pcen, bus.memwrite, bus.irwrite, bus.regwrite, bus.iord, bus.memtoreg,
                   bus.regdst, bus.alusrca, bus.alusrcb, bus.pcsrc, bus.alucontrol, bus.illegal};

    function automatic logic [15:0] ov(input logic [7:0] en, input logic [1:0] sb,
                                       input logic [1:0] ps, input logic [2:0] ac, input logic ill);
        return {en, sb, ps, ac, ill};
    endfunction

    task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%h expected=%h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic expect_cyc(input string tag, input state_t st, input logic [15:0] v);
        #1;
        check({tag, "_state"}, 16'(dut.state), 16'(st));
        check({tag, "_outs"}, outs, v);
    endtask

    // Hand-derived per-state vectors
    logic [15:0] V_ZERO, V_FETCH, V_FSTALL, V_DEC, V_DECILL, V_MADR, V_MRD, V_MWB, V_MWR;
    logic [15:0] V_EXSUB, V_AWB, V_BRZ1, V_BRZ0, V_AIEX, V_AIWB, V_JMP;

    initial begin
        #100000;
        $display("FAIL watchdog got=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        V_ZERO   = 16'h0000;
        V_FETCH  = ov(8'b1010_0000, 2'b01, 2'b00, 3'b010, 1'b0);
        V_FSTALL = ov(8'b0000_0000, 2'b01, 2'b00, 3'b010, 1'b0);
        V_DEC    = ov(8'b0000_0000, 2'b11, 2'b00, 3'b010, 1'b0);
        V_DECILL = ov(8'b0000_0000, 2'b11, 2'b00, 3'b010, 1'b1);
        V_MADR   = ov(8'b0000_0001, 2'b10, 2'b00, 3'b010, 1'b0);
        V_MRD    = ov(8'b0000_1000, 2'b00, 2'b00, 3'b010, 1'b0);
        V_MWB    = ov(8'b0001_0100, 2'b00, 2'b00, 3'b010, 1'b0);
        V_MWR    = ov(8'b0100_1000, 2'b00, 2'b00, 3'b010, 1'b0);
        V_EXSUB  = ov(8'b0000_0001, 2'b00, 2'b00, 3'b110, 1'b0);
        V_AWB    = ov(8'b0001_0010, 2'b00, 2'b00, 3'b010, 1'b0);
        V_BRZ1   = ov(8'b1000_0001, 2'b00, 2'b01, 3'b110, 1'b0);
        V_BRZ0   = ov(8'b0000_0001, 2'b00, 2'b01, 3'b110, 1'b0);
        V_AIEX   = ov(8'b0000_0001, 2'b10, 2'b00, 3'b010, 1'b0);
        V_AIWB   = ov(8'b0001_0000, 2'b00, 2'b00, 3'b010, 1'b0);
        V_JMP    = ov(8'b1000_0000, 2'b00, 2'b10, 3'b010, 1'b0);

        reset_n = 1'b0; bus.op = 6'b0; bus.funct = 6'b0; bus.zero = 1'b0; bus.mem_ready = 1'b1;
        tick(); tick();
        expect_cyc("rst", S_FETCH, V_ZERO);

        reset_n = 1'b1; bus.op = 6'b100011;
        expect_cyc("idle", S_FETCH, V_ZERO);

        // lw: 5 cycles
        tick(); expect_cyc("lw_f", S_FETCH, V_FETCH);
        tick(); expect_cyc("lw_d", S_DECODE, V_DEC);
        tick(); expect_cyc("lw_a", S_MEMADR, V_MADR);
        tick(); expect_cyc("lw_r", S_MEMRD, V_MRD);
        tick(); expect_cyc("lw_wb", S_MEMWB, V_MWB);

        // R-type sub: 4 cycles
        tick(); bus.op = 6'b000000; bus.funct = 6'b100010;
        expect_cyc("sub_f", S_FETCH, V_FETCH);
        tick(); expect_cyc("sub_d", S_DECODE, V_DEC);
        tick(); expect_cyc("sub_ex", S_EXECUTE, V_EXSUB);
        tick(); expect_cyc("sub_wb", S_ALUWB, V_AWB);

        // beq taken then not taken
        tick(); bus.op = 6'b000100;
        expect_cyc("beq1_f", S_FETCH, V_FETCH);
        tick(); expect_cyc("beq1_d", S_DECODE, V_DEC);
        tick(); bus.zero = 1'b1; expect_cyc("beq1_b", S_BRANCH, V_BRZ1);
        tick(); bus.zero = 1'b0; expect_cyc("beq0_f", S_FETCH, V_FETCH);
        tick(); expect_cyc("beq0_d", S_DECODE, V_DEC);
        tick(); expect_cyc("beq0_b", S_BRANCH, V_BRZ0);

        // sw with three stall cycles in MEMWR
        tick(); bus.op = 6'b101011;
        expect_cyc("sw_f", S_FETCH, V_FETCH);
        tick(); expect_cyc("sw_d", S_DECODE, V_DEC);
        tick(); expect_cyc("sw_a", S_MEMADR, V_MADR);
        for (int i = 0; i < 3; i++) begin
            tick(); bus.mem_ready = 1'b0; expect_cyc("sw_stall", S_MEMWR, V_MWR);
        end
        tick(); bus.mem_ready = 1'b1; expect_cyc("sw_w", S_MEMWR, V_MWR);

        // addi
        tick(); bus.op = 6'b001000;
        expect_cyc("addi_f", S_FETCH, V_FETCH);
        tick(); expect_cyc("addi_d", S_DECODE, V_DEC);
        tick(); expect_cyc("addi_ex", S_ADDIEXEC, V_AIEX);
        tick(); expect_cyc("addi_wb", S_ADDIWB, V_AIWB);

        // j, preceded by a fetch stall
        tick(); bus.op = 6'b000010; bus.mem_ready = 1'b0;
        expect_cyc("j_fstall", S_FETCH, V_FSTALL);
        tick(); bus.mem_ready = 1'b1; expect_cyc("j_f", S_FETCH, V_FETCH);
        tick(); expect_cyc("j_d", S_DECODE, V_DEC);
        tick(); expect_cyc("j_j", S_JUMP, V_JMP);

        // illegal opcode, illegal funct, andi without IMM_LOGIC_EN
        tick(); bus.op = 6'b111111;
        expect_cyc("ill_op_f", S_FETCH, V_FETCH);
        tick(); expect_cyc("ill_op_d", S_DECODE, V_DECILL);
        tick(); bus.op = 6'b000000; bus.funct = 6'b000111;
        expect_cyc("ill_fn_f", S_FETCH, V_FETCH);
        tick(); expect_cyc("ill_fn_d", S_DECODE, V_DECILL);
        tick(); bus.op = 6'b001100;
        expect_cyc("ill_andi_f", S_FETCH, V_FETCH);
        tick(); expect_cyc("ill_andi_d", S_DECODE, V_DECILL);

        // reset during MEMRD stall, then fresh fetch of a jump
        tick(); bus.op = 6'b100011;
        expect_cyc("rr_f", S_FETCH, V_FETCH);
        tick(); expect_cyc("rr_d", S_DECODE, V_DEC);
        tick(); expect_cyc("rr_a", S_MEMADR, V_MADR);
        tick(); bus.mem_ready = 1'b0; expect_cyc("rr_stall", S_MEMRD, V_MRD);
        reset_n = 1'b0;
        tick(); expect_cyc("rr_rst", S_FETCH, V_ZERO);
        reset_n = 1'b1; bus.mem_ready = 1'b1; bus.op = 6'b000010;
        expect_cyc("rr_idle", S_FETCH, V_ZERO);
        tick(); expect_cyc("rr_j_f", S_FETCH, V_FETCH);
        tick(); expect_cyc("rr_j_d", S_DECODE, V_DEC);
        tick(); expect_cyc("rr_j_j", S_JUMP, V_JMP);
        tick(); expect_cyc("rr_back", S_FETCH, V_FETCH);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
